rc4_sched: RTL and testbench
============================

# rc4_sched

RC4 sequencing controller that owns all three ports of the 256×8 S-box RAM (read port 1, write port 2, read/write port 3) and drives them through initialisation, key scheduling (KSA) and keystream generation (PRGA). It sits between the key register file and the S-box RAM. Keystream bytes leave on a valid/ready stream toward the XOR/cipher stage.

## Interface
- KEY_AW, 5, key address width; maximum key length KEY_MAX = 2^KEY_AW bytes
- clk  in  1  single clock; everything is synchronous to its rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a new key; sampled only in IDLE
- stop  in  1  abandon generation; return to IDLE (honoured in every non-IDLE state)
- key_len  in  KEY_AW+1  key length in bytes, 1..KEY_MAX; sampled with start
- key_addr  out  KEY_AW  key byte index (i mod key_len)
- key_byte  in  8  key byte at key_addr, combinational (same-cycle) return
- ram_raddr_1  out  8 / ram_rdata_1  in  8  S-box read port 1
- ram_wen_2, ram_waddr_2, ram_wdata_2  out  1/8/8  S-box write port 2
- ram_wen_3, ram_addr_3, ram_wdata_3  out  1/8/8; ram_rdata_3  in  8  S-box port 3
- busy  out  1  high in every state except IDLE
- ksa_done  out  1  high from the first PRGA state until return to IDLE
- err  out  1  one-cycle pulse when start is rejected
- ks_valid  out  1 / ks_data  out  8 / ks_ready  in  1  keystream stream

## Operation
- RAM contract: read data registered, 1-cycle latency; writes commit at the clock edge; a read presented in the cycle after a write returns the new value.
- Registers: i, j (8 bit, mod-256 wrap), k (KEY_AW bit, wraps to 0 after key_len-1; no divider), si, sj (8 bit).
- States: IDLE, INIT, K_RD, K_J, K_SWAP, P_RD, P_J, P_SWAP, P_T, P_OUT.
- IDLE: on start with 1 ≤ key_len ≤ KEY_MAX, latch key_len and clear i/j/k, then go to INIT. Otherwise start is ignored and err pulses.
- INIT: wen_2=1, waddr_2=i, wdata_2=i, i++. After i=255, go to K_RD with i=0, j=0, k=0.
- K_RD: raddr_1=i; key_addr=k.
- K_J: si=rdata_1; j ← j+si+key_byte (mod 256); addr_3=j_new; ram_wen_3=0.
- K_SWAP: sj=rdata_3. Write wen_2: S[i]←sj. Write wen_3 (addr_3=j): S[j]←si, asserted only when i≠j. i++, k wraps. After i=255, go to P_RD with i=0, j=0; otherwise go to K_RD.
- P_RD: i++; raddr_1=i_new.
- P_J, P_SWAP: same as K_J/K_SWAP, except j ← j+si with no key term.
- P_T: raddr_1 = si+sj (mod 256).
- P_OUT: raddr_1 held; ks_valid=1; ks_data=rdata_1. On ks_valid&ks_ready go to P_RD. Otherwise hold; ks_data stays stable.
- stop: go to IDLE next cycle; ks_valid drops and no RAM write is issued from that cycle on.
- start outside IDLE: ignored, no err.
- Outputs not listed as active in a state are 0 (all wen, ks_valid, err).

## Timing
- Reset: state IDLE; busy, ksa_done, err, ks_valid, all wen = 0; i, j, k, all addresses and data = 0.
- Reset mid-operation overrides everything; IDLE is reached in the following cycle and partial S-box contents are don't-care.
- With start sampled at edge 0:
  - INIT occupies cycles 1–256.
  - KSA occupies cycles 257–1024 (3 cycles per byte).
  - ksa_done rises in cycle 1025.
  - ks_valid first rises in cycle 1029.
- Throughput: 5 cycles per keystream byte with ks_ready held high. Backpressure stalls in P_OUT indefinitely.
- key_byte is used in the same cycle as key_addr is driven (K_RD drives, K_J consumes); key_addr is held across both cycles.

## Test plan
- Key "Key" (4B 65 79, len 3), ks_ready=1 → first ks_valid in cycle 1029; bytes EB 9F 77 81 B7 34 CA 72 A7 19.
- Key "Wiki" (len 4) → 60 44 DB 6D 41 B7. Key "Secret" (len 6) → 04 D4 6B 05 3C A8 7B 59.
- Random ks_ready backpressure on "Key" → identical byte sequence; ks_data stable while ks_valid=1 and ks_ready=0.
- start with key_len=0, then key_len=KEY_MAX+1 → err one-cycle pulse each time; busy stays 0; no RAM write.
- Reset at cycle 600 (mid-KSA), then stop during PRGA → IDLE next cycle with all outputs at reset values. A following start with "Key" reproduces the EB 9F 77… sequence.
- KSA i==j case (key of 32 bytes 0x00 at index 0 → j=0 at i=0) → ram_wen_3=0 in that K_SWAP; final keystream matches a software model.

Source files
------------

// File: rtl/rc4_sched.sv
// RC4 sequencer: fills the S-box, runs key scheduling, then streams keystream bytes.
// Owns all three ports of the 256x8 S-box RAM (registered reads, 1-cycle latency).
module rc4_sched #(
    parameter int KEY_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [KEY_AW:0]   key_len_i,
    output logic [KEY_AW-1:0] key_addr_o,
    input  logic [7:0]        key_byte_i,
    output logic [7:0]        ram_raddr_1_o,
    input  logic [7:0]        ram_rdata_1_i,
    output logic              ram_wen_2_o,
    output logic [7:0]        ram_waddr_2_o,
    output logic [7:0]        ram_wdata_2_o,
    output logic              ram_wen_3_o,
    output logic [7:0]        ram_addr_3_o,
    output logic [7:0]        ram_wdata_3_o,
    input  logic [7:0]        ram_rdata_3_i,
    output logic              busy_o,
    output logic              ksa_done_o,
    output logic              err_o,
    output logic              ks_valid_o,
    output logic [7:0]        ks_data_o,
    input  logic              ks_ready_i
);

    // state | meaning: IDLE wait for start | INIT S[i]=i | K_RD/K_J/K_SWAP KSA read S[i], new j, swap
    // P_RD/P_J/P_SWAP PRGA step i, new j, swap | P_T read S[si+sj] | P_OUT offer keystream byte
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_K_RD, S_K_J, S_K_SWAP,
        S_P_RD, S_P_J, S_P_SWAP, S_P_T, S_P_OUT
    } state_t;

    localparam logic [KEY_AW:0] KEY_MAX = {1'b1, {KEY_AW{1'b0}}};
    localparam logic [KEY_AW:0] LEN_ONE = {{KEY_AW{1'b0}}, 1'b1};

    state_t            state_q;
    logic [KEY_AW:0]   key_len_q;
    logic [7:0]        i_q, j_q, si_q, sj_q;
    logic [KEY_AW-1:0] k_q;
    logic              busy_q, ksa_done_q, err_q, ks_valid_q;

    logic [7:0] key_term;
    logic [7:0] j_new;
    logic       len_ok;
    logic       k_last;

    assign len_ok   = (key_len_i != '0) && (key_len_i <= KEY_MAX);
    assign k_last   = ({1'b0, k_q} == (key_len_q - LEN_ONE));
    assign key_term = (state_q == S_K_J) ? key_byte_i : 8'd0;
    assign j_new    = j_q + ram_rdata_1_i + key_term;

    always_ff @(posedge clk_i) begin
        if (rst_i || (stop_i && (state_q != S_IDLE))) begin
            state_q    <= S_IDLE;
            key_len_q  <= '0;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            k_q        <= '0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            busy_q     <= 1'b0;
            ksa_done_q <= 1'b0;
            err_q      <= 1'b0;
            ks_valid_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_ok) begin
                            key_len_q <= key_len_i;
                            i_q       <= 8'd0;
                            j_q       <= 8'd0;
                            k_q       <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_INIT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    i_q <= i_q + 8'd1;
                    if (i_q == 8'hFF) state_q <= S_K_RD;
                end
                S_K_RD: state_q <= S_K_J;
                S_K_J, S_P_J: begin
                    si_q    <= ram_rdata_1_i;
                    j_q     <= j_new;
                    state_q <= (state_q == S_K_J) ? S_K_SWAP : S_P_SWAP;
                end
                S_K_SWAP: begin
                    sj_q <= ram_rdata_3_i;
                    k_q  <= k_last ? '0 : k_q + KEY_AW'(1);
                    if (i_q == 8'hFF) begin
                        // i wraps to 0 and P_RD pre-increments it, so enter PRGA with i=1
                        i_q        <= 8'd1;
                        j_q        <= 8'd0;
                        ksa_done_q <= 1'b1;
                        state_q    <= S_P_RD;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        state_q <= S_K_RD;
                    end
                end
                S_P_RD: state_q <= S_P_J;
                S_P_SWAP: begin
                    sj_q    <= ram_rdata_3_i;
                    state_q <= S_P_T;
                end
                S_P_T: begin
                    ks_valid_q <= 1'b1;
                    state_q    <= S_P_OUT;
                end
                S_P_OUT: begin
                    if (ks_ready_i) begin
                        ks_valid_q <= 1'b0;
                        i_q        <= i_q + 8'd1;
                        state_q    <= S_P_RD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_raddr_1_o = 8'd0;
        ram_wen_2_o   = 1'b0;
        ram_waddr_2_o = 8'd0;
        ram_wdata_2_o = 8'd0;
        ram_wen_3_o   = 1'b0;
        ram_addr_3_o  = 8'd0;
        ram_wdata_3_o = 8'd0;
        case (state_q)
            S_INIT: begin
                ram_wen_2_o   = 1'b1;
                ram_waddr_2_o = i_q;
                ram_wdata_2_o = i_q;
            end
            S_K_RD, S_P_RD: ram_raddr_1_o = i_q;
            S_K_J, S_P_J:   ram_addr_3_o  = j_new;
            S_K_SWAP, S_P_SWAP: begin
                ram_wen_2_o   = 1'b1;
                ram_waddr_2_o = i_q;
                ram_wdata_2_o = ram_rdata_3_i;
                ram_wen_3_o   = (i_q != j_q);
                ram_addr_3_o  = j_q;
                ram_wdata_3_o = si_q;
            end
            S_P_T, S_P_OUT: ram_raddr_1_o = si_q + sj_q;
            default: ;
        endcase
        // an abandoned key must not disturb the S-box any further
        if (stop_i) begin
            ram_wen_2_o = 1'b0;
            ram_wen_3_o = 1'b0;
        end
    end

    assign key_addr_o = k_q;
    assign busy_o     = busy_q;
    assign ksa_done_o = ksa_done_q;
    assign err_o      = err_q;
    assign ks_valid_o = ks_valid_q;
    assign ks_data_o  = (state_q == S_P_OUT) ? ram_rdata_1_i : 8'd0;

endmodule

// File: tb/tb_rc4_sched.sv
// Bench for rc4_sched: behavioural 3-port S-box RAM, key memory and a keystream scoreboard.
module tb_rc4_sched;
    localparam int KEY_AW = 5;

    logic              clk = 1'b0;
    logic              rst, start, stop, ks_ready;
    logic [KEY_AW:0]   key_len;
    logic [KEY_AW-1:0] key_addr;
    logic [7:0]        key_byte;
    logic [7:0]        ram_raddr_1, ram_rdata_1;
    logic              ram_wen_2;
    logic [7:0]        ram_waddr_2, ram_wdata_2;
    logic              ram_wen_3;
    logic [7:0]        ram_addr_3, ram_wdata_3, ram_rdata_3;
    logic              busy, ksa_done, err, ks_valid;
    logic [7:0]        ks_data;

    logic [7:0] sram    [256];
    logic [7:0] key_mem [32];
    logic [7:0] exp_q   [$];
    int         checks   = 0;
    int         failures = 0;
    int         wr_count = 0;
    logic [63:0] out_vec;

    rc4_sched #(.KEY_AW(KEY_AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .key_len_i(key_len), .key_addr_o(key_addr), .key_byte_i(key_byte),
        .ram_raddr_1_o(ram_raddr_1), .ram_rdata_1_i(ram_rdata_1),
        .ram_wen_2_o(ram_wen_2), .ram_waddr_2_o(ram_waddr_2), .ram_wdata_2_o(ram_wdata_2),
        .ram_wen_3_o(ram_wen_3), .ram_addr_3_o(ram_addr_3), .ram_wdata_3_o(ram_wdata_3),
        .ram_rdata_3_i(ram_rdata_3),
        .busy_o(busy), .ksa_done_o(ksa_done), .err_o(err),
        .ks_valid_o(ks_valid), .ks_data_o(ks_data), .ks_ready_i(ks_ready)
    );

    always #5 clk = ~clk;

    assign key_byte = key_mem[key_addr];
    assign out_vec  = {2'b00, busy, ksa_done, err, ks_valid, ram_wen_2, ram_wen_3,
                       ram_raddr_1, ram_waddr_2, ram_wdata_2, ram_addr_3, ram_wdata_3,
                       3'b000, key_addr, ks_data};

    always @(posedge clk) begin
        if (ram_wen_2) sram[ram_waddr_2] <= ram_wdata_2;
        if (ram_wen_3) sram[ram_addr_3]  <= ram_wdata_3;
        ram_rdata_1 <= sram[ram_raddr_1];
        ram_rdata_3 <= sram[ram_addr_3];
        if (ram_wen_2 || ram_wen_3) wr_count <= wr_count + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_key();
        for (int a = 0; a < 32; a++) key_mem[a] = 8'h00;
    endtask

    // textbook RC4 over key_mem, used where no published vector exists
    task automatic rc4_model(input int len, input int nbytes);
        logic [7:0] s [256];
        logic [7:0] t;
        int i, j;
        for (int a = 0; a < 256; a++) s[a] = a[7:0];
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + int'(s[a]) + int'(key_mem[a % len])) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int b = 0; b < nbytes; b++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            exp_q.push_back(s[(int'(s[i]) + int'(s[j])) % 256]);
        end
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        key_len  = len[KEY_AW:0];
        start    = 1'b1;
        ks_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int len, input int nbytes, input bit rand_rdy);
        int n, got, first_done, first_valid, last_v;
        bit stall, prev_v;
        logic [7:0] held, e;
        pulse_start(len);
        n = 0; got = 0; first_done = 0; first_valid = 0; last_v = 0;
        stall = 1'b0; prev_v = 1'b0; held = 8'h00;
        while (got < nbytes && n < 20000) begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, "_busy_init"}, {63'd0, busy}, 64'd1);
            if (n == 259) begin
                chk({tag, "_swap0_wen2"}, {63'd0, ram_wen_2}, 64'd1);
                chk({tag, "_swap0_wen3"}, {63'd0, ram_wen_3}, {63'd0, key_mem[0] != 8'h00});
                chk({tag, "_swap0_addr3"}, {56'd0, ram_addr_3}, {56'd0, key_mem[0]});
            end
            if (first_done == 0 && ksa_done) first_done = n;
            if (first_valid == 0 && ks_valid) first_valid = n;
            if (!rand_rdy && ks_valid && !prev_v) begin
                if (last_v != 0) chk({tag, "_period"}, 64'(n - last_v), 64'd5);
                last_v = n;
            end
            prev_v = ks_valid;
            if (stall) begin
                chk({tag, "_stall_valid"}, {63'd0, ks_valid}, 64'd1);
                chk({tag, "_stall_data"}, {56'd0, ks_data}, {56'd0, held});
            end
            ks_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ks_valid && ks_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_q_underflow"}, 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_ks_byte"}, {56'd0, ks_data}, {56'd0, e});
                end
                got++;
                stall = 1'b0;
            end else if (ks_valid) begin
                stall = 1'b1;
                held  = ks_data;
            end else begin
                stall = 1'b0;
            end
        end
        chk({tag, "_timeout"}, {63'd0, n >= 20000}, 64'd0);
        chk({tag, "_ksa_done_cycle"}, 64'(first_done), 64'd1025);
        chk({tag, "_first_valid_cycle"}, 64'(first_valid), 64'd1029);
        chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_stop(input string tag);
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        ks_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_stop_idle"}, out_vec, 64'd0);
    endtask

    task automatic bad_start(input string tag, input int len);
        int w0;
        @(negedge clk);
        w0       = wr_count;
        key_len  = len[KEY_AW:0];
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({tag, "_err_hi"}, {63'd0, err}, 64'd1);
        chk({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk({tag, "_err_pulse"}, {63'd0, err}, 64'd0);
        chk({tag, "_no_write"}, 64'(wr_count - w0), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ks_ready = 1'b1; key_len = '0;
        clear_key();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", out_vec, 64'd0);

        bad_start("len0", 0);
        bad_start("len33", 33);

        clear_key();
        key_mem[0] = 8'h4B; key_mem[1] = 8'h65; key_mem[2] = 8'h79;
        exp_q = {8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run_stream("key", 3, 10, 1'b0);
        do_stop("key");

        clear_key();
        key_mem[0] = 8'h57; key_mem[1] = 8'h69; key_mem[2] = 8'h6B; key_mem[3] = 8'h69;
        exp_q = {8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
        run_stream("wiki", 4, 6, 1'b0);
        do_stop("wiki");

        clear_key();
        key_mem[0] = 8'h53; key_mem[1] = 8'h65; key_mem[2] = 8'h63;
        key_mem[3] = 8'h72; key_mem[4] = 8'h65; key_mem[5] = 8'h74;
        exp_q = {8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};
        run_stream("secret", 6, 8, 1'b0);
        do_stop("secret");

        clear_key();
        key_mem[0] = 8'h4B; key_mem[1] = 8'h65; key_mem[2] = 8'h79;
        exp_q = {8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run_stream("key_bp", 3, 10, 1'b1);
        do_stop("key_bp");

        pulse_start(3);
        repeat (600) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midksa_reset", out_vec, 64'd0);
        exp_q = {8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run_stream("key_again", 3, 10, 1'b0);
        do_stop("key_again");

        clear_key();
        rc4_model(32, 16);
        run_stream("zero32", 32, 16, 1'b0);
        do_stop("zero32");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
